// File: rtl/stopwatch_btn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_btn_ctrl_pkg
// Purpose : Shared definitions for the stopwatch push-button conditioner:
//           per-channel debounce FSM state encoding and default timing.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package stopwatch_btn_ctrl_pkg;

    // Debounce/classification FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_CHK = 3'd1,
        ST_HELD      = 3'd2,
        ST_LONG_HELD = 3'd3,
        ST_REL_CHK   = 3'd4
    } btn_state_t;

    // Default timing at a 1 kHz clock: 20 ms debounce, 1 s long press
    localparam int c_DEB_CYC_DEFAULT  = 20;
    localparam int c_LONG_CYC_DEFAULT = 1000;

endpackage : stopwatch_btn_ctrl_pkg
`default_nettype wire

// File: rtl/stopwatch_btn_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Purpose : One button channel: 2-FF synchronizer, debounce filter and
//           click / long-press classification.
// Ports   : clk        - clock, rising edge
//           rst        - synchronous reset, active-high
//           i_btn_raw  - asynchronous raw button, 1 = pressed
//           o_level    - debounced level
//           o_click    - 1-cycle pulse on accepted release of a short press
//           o_long     - 1-cycle pulse when a hold reaches LONG_CYC
// Rev     : 1.0  initial release
// ============================================================================
module btn_debounce
    import stopwatch_btn_ctrl_pkg::*;
#(
    parameter int DEB_CYC  = c_DEB_CYC_DEFAULT,   // >= 2
    parameter int LONG_CYC = c_LONG_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_click,
    output logic o_long
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int HW = $clog2(LONG_CYC + 1);

    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(DEB_CYC - 1);
    localparam logic [HW-1:0] c_HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] c_HOLD_MAX  = HW'(LONG_CYC);

    btn_state_t    r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_long_flag;
    logic          r_level;
    logic          r_click;
    logic          r_long;

    logic w_s;
    assign w_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sync      <= 2'b00;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_long_flag <= 1'b0;
            r_level     <= 1'b0;
            r_click     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_raw};
            r_click <= 1'b0;
            r_long  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        r_state <= ST_PRESS_CHK;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!w_s) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_HELD;
                        r_level <= 1'b1;
                        r_hold  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!w_s) begin
                        r_state     <= ST_REL_CHK;
                        r_cnt       <= c_CNT_ONE;
                        r_long_flag <= 1'b0;
                    end else begin
                        // Saturating hold counter; frozen while a release is checked
                        if (r_hold != c_HOLD_MAX) begin
                            r_hold <= r_hold + c_HOLD_ONE;
                        end
                        if (r_hold == c_HOLD_LAST) begin
                            r_state <= ST_LONG_HELD;
                            r_long  <= 1'b1;
                        end
                    end
                end
                ST_LONG_HELD: begin
                    if (!w_s) begin
                        r_state     <= ST_REL_CHK;
                        r_cnt       <= c_CNT_ONE;
                        r_long_flag <= 1'b1;
                    end
                end
                ST_REL_CHK: begin
                    if (w_s) begin
                        // Release bounce: resume where the hold left off
                        r_state <= r_long_flag ? ST_LONG_HELD : ST_HELD;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                        r_click <= ~r_long_flag;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_level = r_level;
    assign o_click = r_click;
    assign o_long  = r_long;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/stopwatch_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_btn_ctrl
// Purpose : Conditions the raw stopwatch push-buttons and derives the
//           StopWatch run level and clear request from channel 0.
// Ports   : clk1k      - 1 kHz clock, rising edge
//           sw_reset   - synchronous reset, active-high
//           btn_raw    - raw buttons [NBTN], 1 = pressed
//           btn_level  - debounced levels [NBTN]
//           btn_click  - short-press release pulses [NBTN]
//           btn_long   - long-press pulses [NBTN]
//           run        - start/stop level (-> sw_strtstop)
//           clr_pulse  - 1-cycle clear request (ORed into StopWatch reset)
// Rev     : 1.0  initial release
// ============================================================================
module stopwatch_btn_ctrl
    import stopwatch_btn_ctrl_pkg::*;
#(
    parameter int NBTN     = 2,
    parameter int DEB_CYC  = c_DEB_CYC_DEFAULT,
    parameter int LONG_CYC = c_LONG_CYC_DEFAULT
) (
    input  logic            clk1k,
    input  logic            sw_reset,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_click,
    output logic [NBTN-1:0] btn_long,
    output logic            run,
    output logic            clr_pulse
);

    logic [NBTN-1:0] w_level;
    logic [NBTN-1:0] w_click;
    logic [NBTN-1:0] w_long;
    logic            r_run;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC)
        ) u_btn (
            .clk       (clk1k),
            .rst       (sw_reset),
            .i_btn_raw (btn_raw[gi]),
            .o_level   (w_level[gi]),
            .o_click   (w_click[gi]),
            .o_long    (w_long[gi])
        );
    end

    // Long press wins over click; both cannot coincide on one channel anyway
    always_ff @(posedge clk1k) begin
        if (sw_reset) begin
            r_run <= 1'b0;
        end else if (w_long[0]) begin
            r_run <= 1'b0;
        end else if (w_click[0]) begin
            r_run <= ~r_run;
        end
    end

    assign btn_level = w_level;
    assign btn_click = w_click;
    assign btn_long  = w_long;
    assign run       = r_run;
    // w_long is already a registered 1-cycle pulse, so the clear aligns with it
    assign clr_pulse = w_long[0];

endmodule : stopwatch_btn_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_btn_ctrl
// Purpose : Self-checking bench for stopwatch_btn_ctrl. Directed stimulus
//           pushes expected output transitions (name and cycle) into a
//           queue; an independent monitor compares every observed output
//           transition against the queue head.
// Rev     : 1.0  initial release
// ============================================================================
module tb_stopwatch_btn_ctrl;

    localparam int NBTN = 2;

    logic            clk1k = 1'b0;
    logic            sw_reset;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_click;
    logic [NBTN-1:0] btn_long;
    logic            run;
    logic            clr_pulse;

    stopwatch_btn_ctrl #(
        .NBTN     (NBTN),
        .DEB_CYC  (20),
        .LONG_CYC (1000)
    ) dut (
        .clk1k     (clk1k),
        .sw_reset  (sw_reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_click (btn_click),
        .btn_long  (btn_long),
        .run       (run),
        .clr_pulse (clr_pulse)
    );

    always #5 clk1k = ~clk1k;

    int cyc = 0;
    always @(posedge clk1k) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    bit  mon_en  = 1'b0;

    logic [NBTN-1:0] p_level, p_click, p_long;
    logic            p_run, p_clr;

    task automatic expect_ev(input string nm, input int at);
        ev_t e;
        e.name = nm;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Expected events whose cycle has passed without being observed
    task automatic drain_missed();
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_total++;
            $display("FAIL missed_event: expected %s at cycle %0d, not seen by cycle %0d",
                     exp_q[0].name, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic observe(input string nm);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %s at cycle %0d, expected none", nm, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.name == nm && e.cyc == cyc)
                n_pass++;
            else
                $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         nm, cyc, e.name, e.cyc);
        end
    endtask

    // Monitor: every output transition is an event, checked in a fixed order
    always @(negedge clk1k) begin
        if (mon_en) begin
            drain_missed();
            for (int i = 0; i < NBTN; i++)
                if (btn_level[i] !== p_level[i]) observe($sformatf("level%0d=%0b", i, btn_level[i]));
            for (int i = 0; i < NBTN; i++)
                if (btn_click[i] !== p_click[i]) observe($sformatf("click%0d=%0b", i, btn_click[i]));
            for (int i = 0; i < NBTN; i++)
                if (btn_long[i] !== p_long[i]) observe($sformatf("long%0d=%0b", i, btn_long[i]));
            if (clr_pulse !== p_clr) observe($sformatf("clr=%0b", clr_pulse));
            if (run !== p_run)       observe($sformatf("run=%0b", run));
        end
        p_level = btn_level;
        p_click = btn_click;
        p_long  = btn_long;
        p_clr   = clr_pulse;
        p_run   = run;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk1k);
    endtask

    task automatic check_zero(input string nm);
        logic [3*NBTN+1:0] v;
        v = {btn_level, btn_click, btn_long, run, clr_pulse};
        n_total++;
        if (v == '0) n_pass++;
        else $display("FAIL %s: outputs=%b, expected all 0", nm, v);
    endtask

    int t;

    initial begin
        // 1. Reset with buttons held: outputs 0, no events afterwards
        sw_reset = 1'b1;
        btn_raw  = 2'b11;
        step(3);
        check_zero("reset_state");
        mon_en   = 1'b1;
        sw_reset = 1'b0;
        btn_raw  = 2'b00;
        step(30);

        // 2. Clean 100-cycle click on channel 0
        t = cyc;
        expect_ev("level0=1", t + 22);
        expect_ev("level0=0", t + 122);
        expect_ev("click0=1", t + 122);
        expect_ev("click0=0", t + 123);
        expect_ev("run=1",    t + 123);
        btn_raw = 2'b01;
        step(100);
        btn_raw = 2'b00;
        step(30);

        // 3. Bounce: 5-cycle toggles for 60 cycles produce nothing
        for (int k = 0; k < 12; k++) begin
            btn_raw = (k % 2 == 0) ? 2'b01 : 2'b00;
            step(5);
        end
        btn_raw = 2'b00;
        step(40);

        // 4. Long press with run=1: long + clear at 1022, run drops, no click
        t = cyc;
        expect_ev("level0=1", t + 22);
        expect_ev("long0=1",  t + 1022);
        expect_ev("clr=1",    t + 1022);
        expect_ev("long0=0",  t + 1023);
        expect_ev("clr=0",    t + 1023);
        expect_ev("run=0",    t + 1023);
        expect_ev("level0=0", t + 1522);
        btn_raw = 2'b01;
        step(1500);
        btn_raw = 2'b00;
        step(40);

        // 5. Reset at cycle 500 of a hold: re-acceptance, no stale long
        t = cyc;
        expect_ev("level0=1", t + 22);
        expect_ev("level0=0", t + 501);
        btn_raw = 2'b01;
        step(500);
        sw_reset = 1'b1;
        step(1);
        check_zero("reset_mid_hold");
        step(1);
        sw_reset = 1'b0;
        expect_ev("level0=1", t + 524);
        expect_ev("level0=0", t + 1122);
        expect_ev("click0=1", t + 1122);
        expect_ev("click0=0", t + 1123);
        expect_ev("run=1",    t + 1123);
        step(598);
        btn_raw = 2'b00;
        step(40);

        // 6. Both channels pressed together for 50 cycles
        t = cyc;
        expect_ev("level0=1", t + 22);
        expect_ev("level1=1", t + 22);
        expect_ev("level0=0", t + 72);
        expect_ev("level1=0", t + 72);
        expect_ev("click0=1", t + 72);
        expect_ev("click1=1", t + 72);
        expect_ev("click0=0", t + 73);
        expect_ev("click1=0", t + 73);
        expect_ev("run=0",    t + 73);
        btn_raw = 2'b11;
        step(50);
        btn_raw = 2'b00;
        step(40);

        // Every expected event must have been consumed
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_events: %0d left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_stopwatch_btn_ctrl
`default_nettype wire
